// File: rtl/piano_pkg.sv
// Shared types and constants for the piano note recorder: entry layout, note codes, mode encoding.
// Helper functions turn a pressed-key vector into a note code and a note code back into a tone vector.
package piano_pkg;

    localparam int ENTRY_W = 16;
    localparam int CODE_W  = 5;
    localparam int DUR_W   = 11;
    localparam int KEYS    = 16;

    localparam logic [CODE_W-1:0] REST_CODE = 5'd16;
    localparam logic [DUR_W-1:0]  DUR_MAX   = 11'd2047;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    // Lowest-numbered pressed key wins; REST when nothing is pressed.
    function automatic logic [CODE_W-1:0] note_code(input logic [KEYS-1:0] pressed);
        logic [CODE_W-1:0] code;
        code = REST_CODE;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (pressed[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

    function automatic logic [KEYS-1:0] code_tone(input logic [CODE_W-1:0] code);
        logic [KEYS-1:0] t;
        t = '0;
        if (code != REST_CODE) t[code[3:0]] = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/piano_note_mem.sv
// Note storage: DEPTH x 16 single-write RAM with a registered read port (one cycle read latency).
module piano_note_mem
    import piano_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk_in,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_dat,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_dat
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rd_dat_q;

    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[wr_addr] <= wr_dat;
        rd_dat_q <= mem_q[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/piano_recorder.sv
// Records debounced key changes as {code, duration-in-ticks} entries and plays them back to the beeper.
// Live keys pass through to the tone output whenever the recorder is not playing.
module piano_recorder
    import piano_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 120000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [15:0]            key_out,
    input  logic                   rec_start,
    input  logic                   play_start,
    input  logic                   stop,
    output logic [15:0]            tone,
    output logic                   tone_en,
    output logic [1:0]             mode,
    output logic [$clog2(DEPTH):0] rec_count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV + 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [CODE_W-1:0] cur_code_q, cur_code_d;
    logic              started_q, started_d;
    logic [CW-1:0]     rec_count_q, rec_count_d;
    logic [CW-1:0]     play_idx_q, play_idx_d;
    logic              play_wait_q, play_wait_d;
    logic [15:0]       tone_q, tone_d;
    logic              tone_en_q, tone_en_d;
    logic              full_q, full_d;

    logic              tick;
    logic [CODE_W-1:0] live_code;
    logic              mem_we;
    entry_t            wr_entry;
    logic [ENTRY_W-1:0] rd_dat;
    entry_t            rd_entry;

    assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign live_code = note_code(~key_out);
    assign rd_entry  = rd_dat;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        dur_d       = dur_q;
        rem_d       = rem_q;
        cur_code_d  = cur_code_q;
        started_d   = started_q;
        rec_count_d = rec_count_q;
        play_idx_d  = play_idx_q;
        play_wait_d = 1'b0;
        tone_d      = ~key_out;
        mem_we      = 1'b0;
        wr_entry.code = cur_code_q;
        wr_entry.dur  = (dur_q == '0) ? DUR_W'(1) : dur_q;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (rec_start) begin
                    state_d     = ST_RECORD;
                    rec_count_d = '0;
                    cur_code_d  = REST_CODE;
                    started_d   = 1'b0;
                    dur_d       = '0;
                end else if (play_start && rec_count_q != '0) begin
                    state_d     = ST_PLAY;
                    play_idx_d  = '0;
                    play_wait_d = 1'b1;
                end
            end
            ST_RECORD: begin
                dur_d = (tick && dur_q != DUR_MAX) ? dur_q + DUR_W'(1) : dur_q;
                if (stop) begin
                    state_d = ST_IDLE;
                    if (cur_code_q != REST_CODE) begin
                        mem_we      = 1'b1;
                        rec_count_d = rec_count_q + CW'(1);
                    end
                end else if (live_code != cur_code_q) begin
                    cur_code_d = live_code;
                    dur_d      = tick ? DUR_W'(1) : '0;
                    started_d  = 1'b1;
                    // The change cycle before the first key press only ends the leading rest.
                    if (started_q) begin
                        mem_we      = 1'b1;
                        rec_count_d = rec_count_q + CW'(1);
                        if (rec_count_q == CW'(DEPTH - 1)) state_d = ST_IDLE;
                    end
                end
            end
            ST_PLAY: begin
                tone_d = tone_q;
                if (stop) begin
                    state_d = ST_IDLE;
                    tone_d  = '0;
                end else if (play_wait_q || (tick && rem_q == DUR_W'(1))) begin
                    if (play_idx_q == rec_count_q) begin
                        state_d = ST_IDLE;
                        tone_d  = ~key_out;
                    end else begin
                        // Loading restarts the tick phase so the first entry gets whole ticks.
                        tone_d     = code_tone(rd_entry.code);
                        rem_d      = rd_entry.dur;
                        play_idx_d = play_idx_q + CW'(1);
                        tick_cnt_d = '0;
                    end
                end else if (tick) begin
                    rem_d = rem_q - DUR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) tick_cnt_d = '0;
        tone_en_d = |tone_d;
        full_d    = (rec_count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            dur_q       <= '0;
            rem_q       <= '0;
            cur_code_q  <= REST_CODE;
            started_q   <= 1'b0;
            rec_count_q <= '0;
            play_idx_q  <= '0;
            play_wait_q <= 1'b0;
            tone_q      <= '0;
            tone_en_q   <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            dur_q       <= dur_d;
            rem_q       <= rem_d;
            cur_code_q  <= cur_code_d;
            started_q   <= started_d;
            rec_count_q <= rec_count_d;
            play_idx_q  <= play_idx_d;
            play_wait_q <= play_wait_d;
            tone_q      <= tone_d;
            tone_en_q   <= tone_en_d;
            full_q      <= full_d;
        end
    end

    piano_note_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_en   (mem_we),
        .wr_addr (rec_count_q[AW-1:0]),
        .wr_dat  (wr_entry),
        .rd_addr (play_idx_d[AW-1:0]),
        .rd_dat  (rd_dat)
    );

    assign tone      = tone_q;
    assign tone_en   = tone_en_q;
    assign mode      = state_q;
    assign rec_count = rec_count_q;
    assign full      = full_q;

endmodule

// File: tb/tb_piano_recorder.sv
// Directed bench for piano_recorder with TICK_DIV = 4: passthrough/priority table, record/play, abort, reset, full.
module tb_piano_recorder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] key_out = 16'hFFFF;
    logic        rec_start = 1'b0;
    logic        play_start = 1'b0;
    logic        stop = 1'b0;

    logic [15:0] tone, tone4;
    logic        tone_en, tone_en4;
    logic [1:0]  mode, mode4;
    logic [5:0]  rec_count;
    logic [2:0]  rec_count4;
    logic        full, full4;

    int checks = 0;
    int failures = 0;

    piano_recorder #(.DEPTH(32), .TICK_DIV(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .key_out(key_out), .rec_start(rec_start),
        .play_start(play_start), .stop(stop), .tone(tone), .tone_en(tone_en),
        .mode(mode), .rec_count(rec_count), .full(full)
    );

    piano_recorder #(.DEPTH(4), .TICK_DIV(4)) dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .key_out(key_out), .rec_start(rec_start),
        .play_start(play_start), .stop(stop), .tone(tone4), .tone_en(tone_en4),
        .mode(mode4), .rec_count(rec_count4), .full(full4)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] key;
        logic        rec;
        logic        play;
        logic        stp;
        logic [15:0] exp_tone;
        logic        exp_en;
        logic [1:0]  exp_mode;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_play(input int c);
        if (c >= 2 && c <= 13) return 16'h0004;
        if (c >= 22 && c <= 37) return 16'h0020;
        return 16'h0000;
    endfunction

    initial begin
        vecs[0] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 0};
        vecs[1] = '{16'hFFFB, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 2'd0, 0};
        vecs[2] = '{16'h7FFE, 1'b0, 1'b0, 1'b0, 16'h8001, 1'b1, 2'd0, 0};
        vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 0};
        vecs[4] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 2'd0, 0};
        vecs[5] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 2'd0, 0};
        vecs[6] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd1, 0};
        vecs[7] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 0};
        vecs[8] = '{16'hFFEF, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 2'd1, 0};
        vecs[9] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2'd0, 1};

        // Reset state
        key_out = 16'h0000;
        rst_in = 1'b1;
        step();
        step();
        chk("rst_tone", tone, 16'h0000);
        chk("rst_en", tone_en, 1'b0);
        chk("rst_mode", mode, 2'd0);
        chk("rst_count", rec_count, 6'd0);
        chk("rst_full", full, 1'b0);
        rst_in = 1'b0;

        // Passthrough, priority and ignored-pulse table
        for (int i = 0; i < 10; i++) begin
            key_out    = vecs[i].key;
            rec_start  = vecs[i].rec;
            play_start = vecs[i].play;
            stop       = vecs[i].stp;
            step();
            rec_start = 1'b0;
            play_start = 1'b0;
            stop = 1'b0;
            chk($sformatf("vec%0d_tone", i), tone, vecs[i].exp_tone);
            chk($sformatf("vec%0d_en", i), tone_en, vecs[i].exp_en);
            chk($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
            chk($sformatf("vec%0d_count", i), rec_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_full", i), full, 1'b0);
        end

        // Record key 2 for 3 ticks, rest for 2, key 5 for 4, then stop
        rst_in = 1'b1;
        key_out = 16'hFFFF;
        step();
        rst_in = 1'b0;
        rec_start = 1'b1;
        key_out = 16'hFFFB;
        step();
        rec_start = 1'b0;
        chk("rec_mode", mode, 2'd1);
        for (int n = 1; n <= 36; n++) begin
            key_out = (n <= 12) ? 16'hFFFB : (n <= 20) ? 16'hFFFF : 16'hFFDF;
            step();
            if (n == 1)  chk("rec_passthru", tone, 16'h0004);
            if (n == 12) chk("rec_count_e0", rec_count, 6'd0);
            if (n == 13) chk("rec_count_e1", rec_count, 6'd1);
            if (n == 21) chk("rec_count_e2", rec_count, 6'd2);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        key_out = 16'hFFFF;
        chk("rec_stop_mode", mode, 2'd0);
        chk("rec_stop_count", rec_count, 6'd3);
        chk("rec_stop_full", full, 1'b0);

        // Full playback
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        chk("play_mode", mode, 2'd2);
        chk("play_c1_tone", tone, 16'h0000);
        for (int c = 2; c <= 38; c++) begin
            step();
            chk($sformatf("play_c%0d_tone", c), tone, exp_play(c));
            if (c == 37) chk("play_last_mode", mode, 2'd2);
        end
        chk("play_end_mode", mode, 2'd0);
        chk("play_end_count", rec_count, 6'd3);

        // Abort during the second entry, then replay from entry 0
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        for (int c = 2; c <= 16; c++) step();
        stop = 1'b1;
        key_out = 16'hFFFB;
        step();
        stop = 1'b0;
        chk("abort_tone", tone, 16'h0000);
        chk("abort_en", tone_en, 1'b0);
        chk("abort_mode", mode, 2'd0);
        step();
        chk("abort_passthru", tone, 16'h0004);
        chk("abort_count", rec_count, 6'd3);
        key_out = 16'hFFFF;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        step();
        chk("replay_tone", tone, 16'h0004);
        chk("replay_mode", mode, 2'd2);
        step();
        step();
        step();

        // Reset in the middle of playback
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("midrst_tone", tone, 16'h0000);
        chk("midrst_en", tone_en, 1'b0);
        chk("midrst_mode", mode, 2'd0);
        chk("midrst_count", rec_count, 6'd0);
        chk("midrst_full", full, 1'b0);
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        chk("midrst_play_ignored", mode, 2'd0);

        // DEPTH = 4 instance: alternating keys fill the memory
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        rec_start = 1'b1;
        key_out = 16'hFFFE;
        step();
        rec_start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            key_out = (((n - 1) / 4) % 2 == 1) ? 16'hFFFD : 16'hFFFE;
            step();
            if (n == 16) begin
                chk("full_pre_mode", mode4, 2'd1);
                chk("full_pre_count", rec_count4, 3'd3);
                chk("full_pre_full", full4, 1'b0);
            end
            if (n == 17) begin
                chk("full_mode", mode4, 2'd0);
                chk("full_flag", full4, 1'b1);
                chk("full_count", rec_count4, 3'd4);
            end
        end
        chk("full_hold_count", rec_count4, 3'd4);
        chk("full_hold_mode", mode4, 2'd0);
        chk("full_passthru", tone4, 16'h0002);
        chk("full_passthru_en", tone_en4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
